// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, ALU operation, bus-D select and FSM encodings shared by the multicycle control unit
package cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_MUL2  = 4'h4;
    localparam logic [3:0] OP_DIV2  = 4'h5;
    localparam logic [3:0] OP_CLR   = 4'h6;
    localparam logic [3:0] OP_RST   = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_STORE = 4'hC;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_ADDI  = 4'h2;
    localparam logic [3:0] ALU_SUBI  = 4'h3;
    localparam logic [3:0] ALU_MUL2  = 4'h4;
    localparam logic [3:0] ALU_DIV2  = 4'h5;
    localparam logic [3:0] ALU_PASSB = 4'h8;

    localparam logic [1:0] MD_ALU  = 2'd0;
    localparam logic [1:0] MD_MEM  = 2'd1;
    localparam logic [1:0] MD_ZERO = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    // wr: ALU/CLR/MOV write-back, ld/st: memory access, jmp/ov/rc: single-cycle EXECUTE pulses
    typedef struct packed {
        logic [3:0] alu;
        logic       mb;
        logic [1:0] md;
        logic       wr;
        logic       ld;
        logic       st;
        logic       jmp;
        logic       ov;
        logic       rc;
        logic       ill;
    } ctl_t;

endpackage

// File: rtl/mcu_decoder.sv
// mcu_decoder: combinational instruction-register to control-field decode
module mcu_decoder
    import cpu_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    localparam int INSTR_W   = OPCODE_W + 2 * REG_ADDR_W
) (
    input  logic [INSTR_W-1:0]    i_ir,
    output logic [REG_ADDR_W-1:0] o_addr_a,
    output logic [REG_ADDR_W-1:0] o_addr_b,
    output logic [DATA_W-1:0]     o_constant,
    output logic [PC_W-1:0]       o_pc_value,
    output ctl_t                  o_ctl
);

    logic [OPCODE_W-1:0] w_op;

    assign w_op       = i_ir[INSTR_W-1 -: OPCODE_W];
    assign o_addr_a   = i_ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign o_addr_b   = i_ir[REG_ADDR_W-1:0];
    assign o_constant = DATA_W'(o_addr_b);
    assign o_pc_value = PC_W'(i_ir[2*REG_ADDR_W-1:0]);

    // map each opcode to its ALU op, bus selects and sequencing class; unknown opcodes are illegal
    always_comb begin
        o_ctl = '0;
        case (w_op)
            OPCODE_W'(OP_ADD):   begin o_ctl.alu = ALU_ADD;   o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_SUB):   begin o_ctl.alu = ALU_SUB;   o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_ADDI):  begin o_ctl.alu = ALU_ADDI;  o_ctl.mb = 1'b1; o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_SUBI):  begin o_ctl.alu = ALU_SUBI;  o_ctl.mb = 1'b1; o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_MUL2):  begin o_ctl.alu = ALU_MUL2;  o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_DIV2):  begin o_ctl.alu = ALU_DIV2;  o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_CLR):   begin o_ctl.md = MD_ZERO;    o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_RST):   o_ctl.rc = 1'b1;
            OPCODE_W'(OP_MOV):   begin o_ctl.alu = ALU_PASSB; o_ctl.md = MD_ALU; o_ctl.wr = 1'b1; end
            OPCODE_W'(OP_JMP):   o_ctl.jmp = 1'b1;
            OPCODE_W'(OP_OUT):   o_ctl.ov = 1'b1;
            OPCODE_W'(OP_LOAD):  begin o_ctl.md = MD_MEM;     o_ctl.ld = 1'b1; end
            OPCODE_W'(OP_STORE): o_ctl.st = 1'b1;
            default:             o_ctl.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer; MCU_ILLEGAL_TRAP_EN makes illegal opcodes halt
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    localparam int INSTR_W   = OPCODE_W + 2 * REG_ADDR_W,
    localparam int NREG      = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] addr_a,
    output logic [REG_ADDR_W-1:0] addr_b,
    output logic [NREG-1:0]       load,
    output logic [3:0]            alu_opcode,
    output logic                  mb_select,
    output logic [1:0]            md_select,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  load_pc,
    output logic                  pc_inc,
    output logic [PC_W-1:0]       pc_value,
    output logic [DATA_W-1:0]     constant_in,
    output logic                  reg_clear,
    output logic                  out_valid,
    output logic                  illegal
);

    state_t                r_state;
    state_t                w_next;
    logic [INSTR_W-1:0]    r_ir;
    ctl_t                  w_ctl;
    ctl_t                  r_ctl;
    logic [REG_ADDR_W-1:0] w_a;
    logic [REG_ADDR_W-1:0] w_b;
    logic [REG_ADDR_W-1:0] r_a;
    logic [REG_ADDR_W-1:0] r_b;
    logic [DATA_W-1:0]     w_k;
    logic [DATA_W-1:0]     r_k;
    logic [PC_W-1:0]       w_pcv;
    logic [PC_W-1:0]       r_pcv;

    mcu_decoder #(
        .OPCODE_W   (OPCODE_W),
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W),
        .PC_W       (PC_W)
    ) u_dec (
        .i_ir       (r_ir),
        .o_addr_a   (w_a),
        .o_addr_b   (w_b),
        .o_constant (w_k),
        .o_pc_value (w_pcv),
        .o_ctl      (w_ctl)
    );

    assign addr_a      = r_a;
    assign addr_b      = r_b;
    assign constant_in = r_k;
    assign pc_value    = r_pcv;
    assign alu_opcode  = r_ctl.alu;
    assign mb_select   = r_ctl.mb;
    assign md_select   = r_ctl.md;

    // state register; reset lands in FETCH so strobes drop without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // IR captured in FETCH, decoded fields captured in DECODE and held until the next DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir  <= '0;
            r_ctl <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_pcv <= '0;
        end else begin
            if (r_state == S_FETCH) r_ir <= instruction;
            if (r_state == S_DECODE) begin
                r_ctl <= w_ctl;
                r_a   <= w_a;
                r_b   <= w_b;
                r_k   <= w_k;
                r_pcv <= w_pcv;
            end
        end
    end

    // next state and per-state strobes; pc_inc marks the final cycle of every non-JMP instruction
    always_comb begin
        w_next    = r_state;
        load      = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_pc   = 1'b0;
        pc_inc    = 1'b0;
        reg_clear = 1'b0;
        out_valid = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXECUTE;
            S_EXECUTE: begin
                load_pc   = r_ctl.jmp;
                reg_clear = r_ctl.rc;
                out_valid = r_ctl.ov;
                illegal   = r_ctl.ill;
                w_next    = (r_ctl.ld || r_ctl.st) ? S_MEM : r_ctl.wr ? S_WRITEBACK : S_FETCH;
`ifdef MCU_ILLEGAL_TRAP_EN
                pc_inc    = r_ctl.rc || r_ctl.ov;
                if (r_ctl.ill) w_next = S_HALT;
`else
                pc_inc    = r_ctl.rc || r_ctl.ov || r_ctl.ill;
`endif
            end
            S_MEM: begin
                mem_read  = r_ctl.ld;
                mem_write = r_ctl.st;
                pc_inc    = mem_ready && r_ctl.st;
                w_next    = !mem_ready ? S_MEM : r_ctl.ld ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                load   = NREG'(1) << r_a;
                pc_inc = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                w_next  = S_HALT;
`else
                w_next  = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle comparison against an instruction-level timing model plus literal pins
module tb_multicycle_control_unit;

`ifdef MCU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] instruction;
    logic       mem_ready;
    logic [2:0] addr_a, addr_b;
    logic [7:0] load;
    logic [3:0] alu_opcode;
    logic       mb_select;
    logic [1:0] md_select;
    logic       mem_read, mem_write, load_pc, pc_inc;
    logic [7:0] pc_value, constant_in;
    logic       reg_clear, out_valid, illegal;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .addr_a(addr_a), .addr_b(addr_b), .load(load), .alu_opcode(alu_opcode),
        .mb_select(mb_select), .md_select(md_select), .mem_read(mem_read),
        .mem_write(mem_write), .load_pc(load_pc), .pc_inc(pc_inc), .pc_value(pc_value),
        .constant_in(constant_in), .reg_clear(reg_clear), .out_valid(out_valid),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic       chk_en = 1'b0;
    logic [7:0] e_load;
    logic       e_mr, e_mw, e_lpc, e_rc, e_ov, e_ill, e_pc;
    logic [2:0] f_a = '0, f_b = '0;
    logic [7:0] f_pcv = '0;
    logic [3:0] f_alu = '0;
    logic       f_mb = 1'b0;
    logic [1:0] f_md = '0;

    string       lit_n[256];
    logic [63:0] lit_a[256], lit_e[256];
    int lit_seq = 0, lit_done = 0;

    int n_cyc = 0, n_pc = 0, n_ld = 0, n_mr = 0, n_mw = 0, n_lpc = 0, n_ill = 0;
    int b_cyc, b_pc, b_ld, b_mr, b_mw, b_lpc, b_ill;
    logic [7:0] cap_load = '0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic lit(input string n, input logic [63:0] a, input logic [63:0] e);
        lit_n[lit_seq] = n;
        lit_a[lit_seq] = a;
        lit_e[lit_seq] = e;
        lit_seq++;
    endtask

    always @(negedge clk) begin
        while (lit_done < lit_seq) begin
            chk(lit_n[lit_done], lit_a[lit_done], lit_e[lit_done]);
            lit_done++;
        end
        if (chk_en) begin
            chk("load", 64'(load), 64'(e_load));
            chk("mem_read", 64'(mem_read), 64'(e_mr));
            chk("mem_write", 64'(mem_write), 64'(e_mw));
            chk("load_pc", 64'(load_pc), 64'(e_lpc));
            chk("pc_inc", 64'(pc_inc), 64'(e_pc));
            chk("reg_clear", 64'(reg_clear), 64'(e_rc));
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("illegal", 64'(illegal), 64'(e_ill));
            chk("addr_a", 64'(addr_a), 64'(f_a));
            chk("addr_b", 64'(addr_b), 64'(f_b));
            chk("constant_in", 64'(constant_in), 64'(f_b));
            chk("pc_value", 64'(pc_value), 64'(f_pcv));
            chk("alu_opcode", 64'(alu_opcode), 64'(f_alu));
            chk("mb_select", 64'(mb_select), 64'(f_mb));
            chk("md_select", 64'(md_select), 64'(f_md));
            n_cyc++;
            if (pc_inc) n_pc++;
            if (load != '0) begin n_ld++; cap_load = load; end
            if (mem_read) n_mr++;
            if (mem_write) n_mw++;
            if (load_pc) n_lpc++;
            if (illegal) n_ill++;
        end
    end

    // one instruction, cycle k=1 is FETCH; w = MEM cycles, noise drives mem_ready outside MEM; upto>0 stops early
    task automatic run(input logic [9:0] ins, input int w, input bit noise, input int upto);
        int op, len, last;
        bit ill, wr;
        op   = int'(ins[9:6]);
        ill  = op >= 13;
        wr   = op <= 6 || op == 8;
        len  = wr ? 4 : op == 11 ? 4 + w : op == 12 ? 3 + w : 3;
        last = upto > 0 ? upto : len;
        b_cyc = n_cyc; b_pc = n_pc; b_ld = n_ld; b_mr = n_mr; b_mw = n_mw; b_lpc = n_lpc; b_ill = n_ill;
        instruction = ins;
        for (int k = 1; k <= last; k++) begin
            bit mem;
            mem = (op == 11 || op == 12) && k >= 4 && k <= 3 + w;
            if (k == 3) begin
                f_a   = ins[5:3];
                f_b   = ins[2:0];
                f_pcv = {2'b00, ins[5:0]};
                f_alu = (op <= 5 || op == 8) ? ins[9:6] : 4'd0;
                f_mb  = op == 2 || op == 3;
                f_md  = op == 6 ? 2'd2 : op == 11 ? 2'd1 : 2'd0;
            end
            mem_ready = mem ? (k == 3 + w) : noise;
            e_load = (k == len && (wr || op == 11)) ? (8'd1 << ins[5:3]) : 8'd0;
            e_mr   = op == 11 && mem;
            e_mw   = op == 12 && mem;
            e_lpc  = op == 9 && k == 3;
            e_rc   = op == 7 && k == 3;
            e_ov   = op == 10 && k == 3;
            e_ill  = ill && (TRAP ? k >= 3 : k == 3);
            e_pc   = k == len && op != 9 && !(TRAP && ill);
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        lit("reset_all_outputs", 64'({load, addr_a, addr_b, alu_opcode, mb_select, md_select, mem_read,
            mem_write, load_pc, pc_inc, pc_value, constant_in, reg_clear, out_valid, illegal}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        f_a = '0; f_b = '0; f_pcv = '0; f_alu = '0; f_mb = 1'b0; f_md = '0;
    endtask

    logic [9:0] alu_prog [9] = '{10'h04A, 10'h05C, 10'h0CF, 10'h130, 10'h171, 10'h1A0, 10'h217, 10'h1C0, 10'h298};

    initial begin
        rst = 1'b0;
        instruction = '0;
        mem_ready = 1'b0;
        #2;
        do_reset();
        // ADDI r5,#3
        run(10'h0AB, 0, 1'b1, 0);
        lit("addi_load_value", 64'(cap_load), 64'h20);
        lit("addi_load_cycles", 64'(n_ld - b_ld), 64'd1);
        lit("addi_pc_inc_count", 64'(n_pc - b_pc), 64'd1);
        lit("addi_constant", 64'(constant_in), 64'h03);
        lit("addi_alu_opcode", 64'(alu_opcode), 64'd2);
        lit("addi_mb_select", 64'(mb_select), 64'd1);
        lit("addi_cycles", 64'(n_cyc - b_cyc), 64'd4);
        // JMP 0x2A
        run(10'h26A, 0, 1'b1, 0);
        lit("jmp_pc_value", 64'(pc_value), 64'h2A);
        lit("jmp_load_pc_count", 64'(n_lpc - b_lpc), 64'd1);
        lit("jmp_pc_inc_count", 64'(n_pc - b_pc), 64'd0);
        lit("jmp_cycles", 64'(n_cyc - b_cyc), 64'd3);
        for (int i = 0; i < 9; i++) run(alu_prog[i], 0, i[0], 0);
        // LOAD r2, ready on third MEM cycle
        run(10'h2D0, 3, 1'b0, 0);
        lit("load_mem_read_cycles", 64'(n_mr - b_mr), 64'd3);
        lit("load_load_value", 64'(cap_load), 64'h04);
        lit("load_md_select", 64'(md_select), 64'd1);
        lit("load_cycles", 64'(n_cyc - b_cyc), 64'd7);
        // STORE r7, ready on MEM entry
        run(10'h338, 1, 1'b0, 0);
        lit("store_mem_write_cycles", 64'(n_mw - b_mw), 64'd1);
        lit("store_addr_a", 64'(addr_a), 64'd7);
        lit("store_load_cycles", 64'(n_ld - b_ld), 64'd0);
        lit("store_cycles", 64'(n_cyc - b_cyc), 64'd4);
        // opcode 0xE
        run(10'h380, 0, 1'b1, 0);
`ifdef MCU_ILLEGAL_TRAP_EN
        instruction = 10'h0AB;
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        lit("halt_illegal", 64'(illegal), 64'd1);
        lit("halt_pc_inc_count", 64'(n_pc - b_pc), 64'd0);
        lit("halt_illegal_cycles", 64'(n_ill - b_ill), 64'd21);
        do_reset();
`else
        lit("illegal_pulses", 64'(n_ill - b_ill), 64'd1);
        lit("illegal_pc_inc_count", 64'(n_pc - b_pc), 64'd1);
        lit("illegal_cycles", 64'(n_cyc - b_cyc), 64'd3);
`endif
        run(10'h0AB, 0, 1'b0, 0);
        // reset during EXECUTE of ADD r6,r1
        run(10'h031, 0, 1'b0, 2);
        lit("pre_reset_addr_a", 64'(addr_a), 64'd6);
        do_reset();
        run(10'h0CF, 0, 1'b1, 0);
        // reset while LOAD is waiting in MEM
        run(10'h2D0, 5, 1'b0, 5);
        lit("pre_reset_mem_read", 64'(mem_read), 64'd1);
        do_reset();
        run(10'h338, 2, 1'b1, 0);
        lit("final_store_cycles", 64'(n_cyc - b_cyc), 64'd5);
        chk_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
